// File: rtl/xram_arbiter_pkg.sv
// Shared XRAM arbiter definitions: bus widths, sequencer states and owner encoding.
package xram_arbiter_pkg;

    localparam int XRAM_AW = 16;
    localparam int XRAM_DW = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } xram_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/xram_arb_select.sv
// Request arbitration for the XRAM port: CPU priority with a DMA anti-starvation counter.
module xram_arb_select
    import xram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sample,
    input  logic cpu_req,
    input  logic dma_req,
    output logic grant,
    output logic owner
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_comb begin
        grant = sample && (cpu_req || dma_req);
        owner = OWN_CPU;
        if (dma_req && (!cpu_req || starve_cnt == LIMIT))
            owner = OWN_DMA;
    end

    // Counts CPU wins only while DMA is actually waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (grant) begin
            if (owner == OWN_DMA || !dma_req)
                starve_cnt <= 4'd0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/xram_arbiter.sv
// External SRAM sharer: arbitrates CPU and DMA, sequences SETUP/ACTIVE/HOLD strobes, returns data.
module xram_arbiter
    import xram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = XRAM_AW,
    parameter int DATA_WIDTH    = XRAM_DW,
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [ADDR_WIDTH-1:0] xram_ma,
    output logic [DATA_WIDTH-1:0] xram_md_out,
    input  logic [DATA_WIDTH-1:0] xram_md_in,
    output logic                  xram_md_oe,
    output logic                  xram_oe_n,
    output logic                  xram_we_n,
    output logic                  xram_busy
);

    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    xram_state_t           state;
    owner_t                own;
    logic                  we_r;
    logic [3:0]            cnt;
    logic                  idle;
    logic                  grant;
    logic                  sel_owner;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign idle = (state == ST_IDLE);

    xram_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clock  (clock),
        .reset  (reset),
        .sample (idle),
        .cpu_req(cpu_req),
        .dma_req(dma_req),
        .grant  (grant),
        .owner  (sel_owner)
    );

    always_comb begin
        sel_we    = sel_owner ? dma_we    : cpu_we;
        sel_addr  = sel_owner ? dma_addr  : cpu_addr;
        sel_wdata = sel_owner ? dma_wdata : cpu_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            own         <= OWN_CPU;
            we_r        <= 1'b0;
            cnt         <= 4'd0;
            xram_ma     <= '0;
            xram_md_out <= '0;
            xram_md_oe  <= 1'b0;
            xram_oe_n   <= 1'b1;
            xram_we_n   <= 1'b1;
            xram_busy   <= 1'b0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Request is latched here; requester inputs are ignored until the next IDLE.
                    if (grant) begin
                        own       <= owner_t'(sel_owner);
                        we_r      <= sel_we;
                        xram_ma   <= sel_addr;
                        xram_busy <= 1'b1;
                        if (sel_we) begin
                            xram_md_out <= sel_wdata;
                            xram_md_oe  <= 1'b1;
                        end
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt       <= 4'd0;
                    xram_oe_n <= we_r;
                    xram_we_n <= !we_r;
                    state     <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (cnt == LAST) begin
                        xram_oe_n <= 1'b1;
                        xram_we_n <= 1'b1;
                        state     <= ST_HOLD;
                        if (own == OWN_DMA) begin
                            dma_ack <= 1'b1;
                            if (!we_r)
                                dma_rdata <= xram_md_in;
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!we_r)
                                cpu_rdata <= xram_md_in;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    xram_md_oe <= 1'b0;
                    xram_busy  <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xram_arbiter.sv
// Scoreboard bench for xram_arbiter with an SRAM model and strobe/ack monitors.
module tb_xram_arbiter;

    localparam int AC = 2;
    localparam int SL = 4;

    typedef struct {
        logic        own;
        logic        rd;
        logic [11:0] data;
    } sb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [15:0] cpu_addr = 0, dma_addr = 0;
    logic [11:0] cpu_wdata = 0, dma_wdata = 0;
    logic        cpu_ack, dma_ack, xram_md_oe, xram_oe_n, xram_we_n, xram_busy;
    logic [11:0] cpu_rdata, dma_rdata, xram_md_out, xram_md_in;
    logic [15:0] xram_ma;

    // narrow/wide strobe builds, CPU side only
    logic        cpu_req1 = 0, cpu_req15 = 0;
    logic        zb = 1'b0;
    logic [15:0] za = 16'h0;
    logic [11:0] zd = 12'h0;
    logic        ack1, dack1, mdoe1, oe1, we1, busy1;
    logic        ack15, dack15, mdoe15, oe15, we15, busy15;
    logic [11:0] rd1, drd1, mdo1, mdi1, rd15, drd15, mdo15, mdi15;
    logic [15:0] ma1, ma15;

    logic [11:0] mem [0:65535];
    sb_t         sb [$];
    sb_t         mon_it;
    int          cyc = 0, tests = 0, fails = 0;
    int          n_oe = 0, n_we = 0, n_mdoe = 0, n_ack = 0, n_cack = 0, n_dack = 0;
    int          n_oe1 = 0, n_oe15 = 0, oe_fall = -1;
    logic        oe_prev = 1'b1;
    logic [11:0] exp_cpu = 0, exp_dma = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    xram_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .xram_ma(xram_ma), .xram_md_out(xram_md_out), .xram_md_in(xram_md_in),
        .xram_md_oe(xram_md_oe), .xram_oe_n(xram_oe_n), .xram_we_n(xram_we_n),
        .xram_busy(xram_busy)
    );

    xram_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req1), .cpu_we(zb), .cpu_addr(za), .cpu_wdata(zd),
        .cpu_ack(ack1), .cpu_rdata(rd1),
        .dma_req(zb), .dma_we(zb), .dma_addr(za), .dma_wdata(zd),
        .dma_ack(dack1), .dma_rdata(drd1),
        .xram_ma(ma1), .xram_md_out(mdo1), .xram_md_in(mdi1),
        .xram_md_oe(mdoe1), .xram_oe_n(oe1), .xram_we_n(we1), .xram_busy(busy1)
    );

    xram_arbiter #(.ACCESS_CYCLES(15)) u_dut15 (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req15), .cpu_we(zb), .cpu_addr(za), .cpu_wdata(zd),
        .cpu_ack(ack15), .cpu_rdata(rd15),
        .dma_req(zb), .dma_we(zb), .dma_addr(za), .dma_wdata(zd),
        .dma_ack(dack15), .dma_rdata(drd15),
        .xram_ma(ma15), .xram_md_out(mdo15), .xram_md_in(mdi15),
        .xram_md_oe(mdoe15), .xram_oe_n(oe15), .xram_we_n(we15), .xram_busy(busy15)
    );

    // Asynchronous SRAM model: data visible while oe_n low, written while we_n low.
    assign xram_md_in = xram_oe_n ? 12'h000 : mem[xram_ma];
    assign mdi1       = oe1  ? 12'h000 : 12'o0111;
    assign mdi15      = oe15 ? 12'h000 : 12'o1515;

    always @(posedge clock)
        if (!xram_we_n && xram_md_oe) mem[xram_ma] <= xram_md_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!xram_oe_n) n_oe++;
        if (xram_md_oe) n_mdoe++;
        if (!xram_we_n) begin
            n_we++;
            chk("md_oe_in_write", {31'd0, xram_md_oe}, 1);
        end
        if (!xram_oe_n && oe_prev) oe_fall = cyc;
        oe_prev = xram_oe_n;
        if (!oe1) n_oe1++;
        if (!oe15) n_oe15++;
        if (cpu_ack || dma_ack) begin
            n_ack++;
            if (cpu_ack) n_cack++;
            if (dma_ack) n_dack++;
            chk("ack_excl", {31'd0, cpu_ack & dma_ack}, 0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, cpu_ack, dma_ack}, 0);
            end else begin
                mon_it = sb.pop_front();
                chk("ack_owner", {31'd0, dma_ack}, {31'd0, mon_it.own});
                if (mon_it.rd) begin
                    if (mon_it.own) exp_dma = mon_it.data;
                    else            exp_cpu = mon_it.data;
                end
                chk("cpu_rdata", {20'd0, cpu_rdata}, {20'd0, exp_cpu});
                chk("dma_rdata", {20'd0, dma_rdata}, {20'd0, exp_dma});
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic drive(input logic own, input logic we, input logic [15:0] a, input logic [11:0] d);
        if (own) begin dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    endtask

    task automatic wait_ack(input logic own, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (own ? dma_ack : cpu_ack) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("ack_timeout", {31'd0, own ? dma_ack : cpu_ack}, 1);
    endtask

    task automatic access(input logic own, input logic we, input logic [15:0] a,
                          input logic [11:0] d, input logic [11:0] expd);
        int n, at;
        sb.push_back('{own, !we, expd});
        drive(own, we, a, d);
        n = cyc;
        wait_ack(own, at);
        if (own) dma_req = 0; else cpu_req = 0;
        chk("latency", at - n, AC + 2);
    endtask

    initial begin
        int s_oe, s_we, s_md, s_ca, s_da, s_ack, n, at, sc;
        mem[16'o07777] = 12'o5252;
        mem[16'h0010]  = 12'o1111;
        mem[16'h0020]  = 12'o2222;
        mem[16'h0040]  = 12'o4321;
        repeat (3) tick();
        chk("rst_oe_n", {31'd0, xram_oe_n}, 1);
        chk("rst_we_n", {31'd0, xram_we_n}, 1);
        chk("rst_busy_mdoe", {30'd0, xram_busy, xram_md_oe}, 0);
        chk("rst_ma_md", {xram_ma, 4'd0, xram_md_out}, 0);
        chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 0);
        chk("rst_rdata", {8'd0, cpu_rdata, dma_rdata}, 0);
        reset = 0;
        tick();

        // CPU read of the top of field 0
        s_oe = n_oe; s_we = n_we; s_md = n_mdoe;
        n = cyc;
        access(0, 0, 16'o07777, 12'o0000, 12'o5252);
        tick();
        chk("rd_oe_width", n_oe - s_oe, AC);
        chk("rd_oe_first", oe_fall - n, 2);
        chk("rd_no_we", n_we - s_we, 0);
        chk("rd_no_mdoe", n_mdoe - s_md, 0);

        // DMA write, then read it back
        s_we = n_we; s_md = n_mdoe; s_ca = n_cack; s_da = n_dack;
        access(1, 1, 16'h8001, 12'o1234, 12'o0000);
        repeat (2) tick();
        chk("wr_mdoe_width", n_mdoe - s_md, AC + 2);
        chk("wr_we_width", n_we - s_we, AC);
        chk("wr_mem", {20'd0, mem[16'h8001]}, {20'd0, 12'o1234});
        chk("wr_dma_ack_once", n_dack - s_da, 1);
        chk("wr_no_cpu_ack", n_cack - s_ca, 0);
        access(1, 0, 16'h8001, 12'o0000, 12'o1234);
        tick();

        // Both held: expect CPU x SL then DMA, repeating
        sc = 0;
        for (int i = 0; i < 10; i++) begin
            if (sc == SL) begin sb.push_back('{1'b1, 1'b1, 12'o2222}); sc = 0; end
            else          begin sb.push_back('{1'b0, 1'b1, 12'o1111}); sc++; end
        end
        s_ack = n_ack;
        drive(0, 0, 16'h0010, 12'h000);
        drive(1, 0, 16'h0020, 12'h000);
        for (int i = 0; i < 10 * (AC + 3) + 20; i++) begin
            tick();
            if (n_ack - s_ack >= 10) break;
        end
        cpu_req = 0; dma_req = 0;
        chk("starve_acks", n_ack - s_ack, 10);
        repeat (4) tick();
        chk("starve_sb_empty", sb.size(), 0);

        // Reset in the 2nd ACTIVE cycle of a write aborts the access
        drive(1, 1, 16'h0030, 12'o7070);
        repeat (3) tick();
        chk("abort_we_active", {31'd0, xram_we_n}, 0);
        reset = 1; dma_req = 0; exp_cpu = 0; exp_dma = 0;
        s_ack = n_ack;
        tick();
        chk("abort_oe_n", {31'd0, xram_oe_n}, 1);
        chk("abort_we_n", {31'd0, xram_we_n}, 1);
        chk("abort_mdoe_busy", {30'd0, xram_md_oe, xram_busy}, 0);
        chk("abort_rdata_clr", {20'd0, cpu_rdata}, 0);
        reset = 0;
        repeat (8) tick();
        chk("abort_no_ack", n_ack - s_ack, 0);
        access(0, 0, 16'o07777, 12'o0000, 12'o5252);
        tick();

        // CPU drops req during SETUP; access still completes
        sb.push_back('{1'b0, 1'b1, 12'o4321});
        drive(0, 0, 16'h0040, 12'h000);
        n = cyc;
        tick();
        chk("setup_busy", {31'd0, xram_busy}, 1);
        cpu_req = 0;
        wait_ack(0, at);
        chk("drop_latency", at - n, AC + 2);
        tick();

        // Narrowest and widest strobe builds
        s_oe = n_oe1; at = -1;
        cpu_req1 = 1; n = cyc;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack1) begin at = cyc; break; end
        end
        cpu_req1 = 0;
        chk("ac1_latency", at - n, 3);
        chk("ac1_rdata", {20'd0, rd1}, {20'd0, 12'o0111});
        tick();
        chk("ac1_oe_width", n_oe1 - s_oe, 1);

        s_oe = n_oe15; at = -1;
        cpu_req15 = 1; n = cyc;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack15) begin at = cyc; break; end
        end
        cpu_req15 = 0;
        chk("ac15_latency", at - n, 17);
        chk("ac15_rdata", {20'd0, rd15}, {20'd0, 12'o1515});
        tick();
        chk("ac15_oe_width", n_oe15 - s_oe, 15);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
